bcd_to_unix: RTL and testbench
==============================

// Module: bcd_to_unix
// PURPOSE
//   Inverse of the counter-to-BCD display path: converts a user-entered BCD calendar
//   date/time into a 64-bit Unix seconds count. Produces the load value and an
//   active-low load strobe for the unix seconds counter (time-set path).
//   Multi-cycle iterative converter with start/busy/done handshake and input validation.
// PARAMETERS
//   COUNTER_W        64  width of counter output (seconds since 1970-01-01 00:00:00)
//   TZ_OFFSET_HOURS   8  local-time offset east of UTC; used only with BCD_TO_UNIX_TZ_EN
// PORTS
//   clk        in   1   system clock
//   reset_n    in   1   asynchronous active-low reset
//   start      in   1   request conversion; sampled only while idle (busy=0)
//   year_bcd   in  16   4 BCD digits, 1970..9999
//   month_bcd  in   8   2 BCD digits, 01..12
//   day_bcd    in   8   2 BCD digits, 01..days-in-month
//   hour_bcd   in   8   00..23
//   min_bcd    in   8   00..59
//   sec_bcd    in   8   00..59
//   busy       out  1   conversion in progress
//   done       out  1   one-cycle pulse at end of every accepted request (ok or error)
//   error      out  1   request rejected; valid from done, held until next accepted start
//   counter    out  COUNTER_W  converted seconds; updates only on successful done
//   load_n     out  1   active-low one-cycle pulse coincident with successful done
// BEHAVIOUR
//   Reset: busy=0, done=0, error=0, counter=0, load_n=1, FSM=IDLE; any reset mid-run aborts.
//   Inputs latched on the start edge; later input changes have no effect. start while busy ignored.
//   FSM: IDLE -> CONV (BCD->binary, per-nibble >9 check) -> CHECK (range check) ->
//     YEAR (1 cycle per year 1970..Y-1, add 365/366 days; skipped if Y=1970) ->
//     MONTH (1 cycle per month 1..M-1, add month length; skipped if M=1) ->
//     SUM (days += D-1; secs = days*86400 + h*3600 + m*60 + s) -> DONE -> IDLE.
//   Leap rule: full Gregorian (div 4, not div 100 unless div 400); 2000 leap, 2100 not.
//   Day range check uses Feb=29 only in leap years; 30-day months reject day 31.
//   Success latency: done/load_n asserted exactly 4+(Y-1970)+(M-1) cycles after start edge.
//   Error (any nibble >9 or any field out of range): CHECK -> DONE; done at start+3,
//     error=1, counter unchanged, load_n stays 1.
//   busy=1 from cycle after start edge through the DONE cycle; deasserts with done.
//   Back-to-back: start may be asserted the cycle after done and is accepted.
//   Arithmetic: day accumulator >=22 bits; product widened to COUNTER_W, no truncation.
// CONFIGURATION
//   BCD_TO_UNIX_TZ_EN defined: inputs are local time; SUM subtracts TZ_OFFSET_HOURS*3600;
//     a result below 0 is reported as error (counter unchanged, load_n=1); latency unchanged.
//   Undefined: inputs treated as UTC; TZ_OFFSET_HOURS ignored.
// TESTING
//   1970-01-01 00:00:00, start -> done at +4, counter=0, load_n low same cycle, error=0.
//   2000-02-29 12:34:56 -> counter=951827696, done at +4+30+1=+35.
//   2038-01-19 03:14:08 -> counter=2147483648 (bit 31 carry, no 32-bit wrap).
//   2100-02-29 / 2023-02-29 / 2024-04-31 / month_bcd=8'h1A -> done at +3, error=1, load_n=1, counter unchanged.
//   start pulsed during busy with new inputs -> ignored, original result; reset_n low mid-YEAR -> all outputs reset, no done.
//   TZ_EN, offset 8: 1970-01-01 08:00:00 -> counter=0; 07:59:59 -> error=1.

Source files
------------

// File: rtl/bcd_to_unix.sv
// bcd_to_unix: iterative converter from a BCD calendar date/time to a Unix seconds count,
// with start/busy/done handshake, input validation and an active-low counter load strobe.
// Optional build macro BCD_TO_UNIX_TZ_EN: inputs are local time, TZ_OFFSET_HOURS east of UTC.
module bcd_to_unix #(
  parameter int COUNTER_W       = 64,
  parameter int TZ_OFFSET_HOURS = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [15:0]          year_bcd,
  input  logic [7:0]           month_bcd,
  input  logic [7:0]           day_bcd,
  input  logic [7:0]           hour_bcd,
  input  logic [7:0]           min_bcd,
  input  logic [7:0]           sec_bcd,
  output logic                 busy,
  output logic                 done,
  output logic                 error,
  output logic [COUNTER_W-1:0] counter,
  output logic                 load_n
);

  typedef enum logic [2:0] {IDLE, CONV, CHECK, YEAR, MONTH, SUM, DONE} state_t;

  localparam logic [COUNTER_W-1:0] TZ_SECS = COUNTER_W'(TZ_OFFSET_HOURS * 3600);

  function automatic logic is_leap(input logic [13:0] y);
    logic [13:0] r4, r100, r400;
    r4   = y % 14'd4;
    r100 = y % 14'd100;
    r400 = y % 14'd400;
    return (r4 == 14'd0) && ((r100 != 14'd0) || (r400 == 14'd0));
  endfunction

  function automatic logic [4:0] month_days(input logic [3:0] m, input logic leap);
    logic [4:0] n;
    case (m)
      4'd2:                                  n = leap ? 5'd29 : 5'd28;
      4'd4, 4'd6, 4'd9, 4'd11:               n = 5'd30;
      4'd1, 4'd3, 4'd5, 4'd7, 4'd8, 4'd10,
      4'd12:                                 n = 5'd31;
      default:                               n = 5'd0;
    endcase
    return n;
  endfunction

  function automatic logic [7:0] bcd2(input logic [7:0] b);
    return 8'(b[7:4]) * 8'd10 + 8'(b[3:0]);
  endfunction

  state_t state_reg, state_next;

  logic [15:0]          year_bcd_reg;
  logic [7:0]           month_bcd_reg, day_bcd_reg, hour_bcd_reg, min_bcd_reg, sec_bcd_reg;
  logic [13:0]          year_reg, iter_year_reg;
  logic [7:0]           month_reg, day_reg, hour_reg, min_reg, sec_reg;
  logic [3:0]           iter_month_reg;
  logic [21:0]          days_reg;
  logic [COUNTER_W-1:0] secs_reg, counter_reg;
  logic                 fail_reg, busy_reg, done_reg, error_reg, load_n_reg;

  logic                 accept;
  logic [55:0]          nibbles;
  logic [13:0]          nib_bad;
  logic                 leap_target, leap_iter, range_bad;
  logic [4:0]           dim_target, dim_iter;
  logic [21:0]          days_total;
  logic [16:0]          tod;
  logic [COUNTER_W-1:0] secs_raw, secs_final;
  logic                 sum_fail;

  assign accept = (state_reg == IDLE) && !busy_reg && start;

  assign nibbles = {year_bcd_reg, month_bcd_reg, day_bcd_reg, hour_bcd_reg, min_bcd_reg, sec_bcd_reg};

  generate
    for (genvar gi = 0; gi < 14; gi++) begin : g_nib
      assign nib_bad[gi] = nibbles[gi*4 +: 4] > 4'd9;
    end
  endgenerate

  assign leap_target = is_leap(year_reg);
  assign leap_iter   = is_leap(iter_year_reg);
  assign dim_target  = month_days(month_reg[3:0], leap_target);
  assign dim_iter    = month_days(iter_month_reg, leap_target);

  // month is bounded first, so month_reg[3:0] is a valid month index whenever it matters
  assign range_bad = (year_reg < 14'd1970) || (month_reg == 8'd0) || (month_reg > 8'd12) ||
                     (day_reg == 8'd0) || (day_reg > {3'b000, dim_target}) ||
                     (hour_reg > 8'd23) || (min_reg > 8'd59) || (sec_reg > 8'd59);

  assign days_total = days_reg + 22'(day_reg) - 22'd1;
  assign tod        = 17'(hour_reg) * 17'd3600 + 17'(min_reg) * 17'd60 + 17'(sec_reg);
  assign secs_raw   = COUNTER_W'(days_total) * COUNTER_W'(17'd86400) + COUNTER_W'(tod);

`ifdef BCD_TO_UNIX_TZ_EN
  assign sum_fail   = secs_raw < TZ_SECS;
  assign secs_final = secs_raw - TZ_SECS;
`else
  logic tz_unused;
  assign tz_unused  = ^TZ_SECS;
  assign sum_fail   = 1'b0;
  assign secs_final = secs_raw;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_reg <= IDLE;
    else          state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:  if (accept) state_next = CONV;
      CONV:  state_next = CHECK;
      CHECK: begin
        if (fail_reg || range_bad)    state_next = DONE;
        else if (year_reg != 14'd1970) state_next = YEAR;
        else if (month_reg != 8'd1)    state_next = MONTH;
        else                           state_next = SUM;
      end
      YEAR: begin
        if (iter_year_reg + 14'd1 == year_reg)
          state_next = (month_reg != 8'd1) ? MONTH : SUM;
      end
      MONTH: if ({4'b0000, iter_month_reg} + 8'd1 == month_reg) state_next = SUM;
      SUM:   state_next = DONE;
      DONE:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      year_bcd_reg   <= '0;
      month_bcd_reg  <= '0;
      day_bcd_reg    <= '0;
      hour_bcd_reg   <= '0;
      min_bcd_reg    <= '0;
      sec_bcd_reg    <= '0;
      year_reg       <= '0;
      month_reg      <= '0;
      day_reg        <= '0;
      hour_reg       <= '0;
      min_reg        <= '0;
      sec_reg        <= '0;
      iter_year_reg  <= '0;
      iter_month_reg <= '0;
      days_reg       <= '0;
      secs_reg       <= '0;
      counter_reg    <= '0;
      fail_reg       <= 1'b0;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
      error_reg      <= 1'b0;
      load_n_reg     <= 1'b1;
    end else begin
      done_reg   <= 1'b0;
      load_n_reg <= 1'b1;
      // busy stays up through the done cycle so a start there is not taken
      if (done_reg) busy_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (accept) begin
            year_bcd_reg  <= year_bcd;
            month_bcd_reg <= month_bcd;
            day_bcd_reg   <= day_bcd;
            hour_bcd_reg  <= hour_bcd;
            min_bcd_reg   <= min_bcd;
            sec_bcd_reg   <= sec_bcd;
            busy_reg      <= 1'b1;
            error_reg     <= 1'b0;
            fail_reg      <= 1'b0;
          end
        end
        CONV: begin
          year_reg  <= 14'(year_bcd_reg[15:12]) * 14'd1000 + 14'(year_bcd_reg[11:8]) * 14'd100 +
                       14'(year_bcd_reg[7:4]) * 14'd10 + 14'(year_bcd_reg[3:0]);
          month_reg <= bcd2(month_bcd_reg);
          day_reg   <= bcd2(day_bcd_reg);
          hour_reg  <= bcd2(hour_bcd_reg);
          min_reg   <= bcd2(min_bcd_reg);
          sec_reg   <= bcd2(sec_bcd_reg);
          fail_reg  <= |nib_bad;
        end
        CHECK: begin
          fail_reg       <= fail_reg | range_bad;
          days_reg       <= '0;
          iter_year_reg  <= 14'd1970;
          iter_month_reg <= 4'd1;
        end
        YEAR: begin
          days_reg      <= days_reg + (leap_iter ? 22'd366 : 22'd365);
          iter_year_reg <= iter_year_reg + 14'd1;
        end
        MONTH: begin
          days_reg       <= days_reg + 22'(dim_iter);
          iter_month_reg <= iter_month_reg + 4'd1;
        end
        SUM: begin
          secs_reg <= secs_final;
          fail_reg <= sum_fail;
        end
        DONE: begin
          done_reg <= 1'b1;
          if (fail_reg) begin
            error_reg <= 1'b1;
          end else begin
            counter_reg <= secs_reg;
            load_n_reg  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy    = busy_reg;
  assign done    = done_reg;
  assign error   = error_reg;
  assign counter = counter_reg;
  assign load_n  = load_n_reg;

endmodule

// File: tb/tb_bcd_to_unix.sv
// Scoreboard testbench for bcd_to_unix: expected results queued at start, compared at done.
module tb_bcd_to_unix;
  localparam int CW  = 64;
  localparam int TZH = 8;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic [15:0]   year_bcd = '0;
  logic [7:0]    month_bcd = '0, day_bcd = '0, hour_bcd = '0, min_bcd = '0, sec_bcd = '0;
  logic          busy, done, error, load_n;
  logic [CW-1:0] counter;

  always #5 clk = ~clk;

  bcd_to_unix #(.COUNTER_W(CW), .TZ_OFFSET_HOURS(TZH)) dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .year_bcd(year_bcd), .month_bcd(month_bcd), .day_bcd(day_bcd),
    .hour_bcd(hour_bcd), .min_bcd(min_bcd), .sec_bcd(sec_bcd),
    .busy(busy), .done(done), .error(error), .counter(counter), .load_n(load_n)
  );

  typedef struct {
    logic        err;
    logic [63:0] secs;
    int          due;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          cyc = 0;
  int          n_checks = 0;
  int          n_errors = 0;
  int          n_txn = 0;
  logic [63:0] last_counter = '0;
  logic        last_err = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp_v, cyc);
    end
  endtask

  function automatic bit leap_y(input int y);
    return (y % 400 == 0) || ((y % 4 == 0) && (y % 100 != 0));
  endfunction

  function automatic int mdays(input int y, input int m);
    case (m)
      2:             return leap_y(y) ? 29 : 28;
      4, 6, 9, 11:   return 30;
      default:       return 31;
    endcase
  endfunction

  function automatic logic [7:0] bcd8(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  function automatic logic [15:0] bcd16(input int v);
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic void model(input logic [15:0] y, input logic [7:0] mo, d, h, mi, s,
                                output logic ok, output logic [63:0] secs, output int lat);
    logic [55:0] all;
    int yi, moi, di, hi, mii, si;
    longint days;
    all = {y, mo, d, h, mi, s};
    ok = 1'b1;
    for (int i = 0; i < 14; i++) if (all[i*4 +: 4] > 4'd9) ok = 1'b0;
    yi  = int'(y[15:12]) * 1000 + int'(y[11:8]) * 100 + int'(y[7:4]) * 10 + int'(y[3:0]);
    moi = int'(mo[7:4]) * 10 + int'(mo[3:0]);
    di  = int'(d[7:4]) * 10 + int'(d[3:0]);
    hi  = int'(h[7:4]) * 10 + int'(h[3:0]);
    mii = int'(mi[7:4]) * 10 + int'(mi[3:0]);
    si  = int'(s[7:4]) * 10 + int'(s[3:0]);
    if (yi < 1970 || moi < 1 || moi > 12 || di < 1 || hi > 23 || mii > 59 || si > 59) ok = 1'b0;
    else if (di > mdays(yi, moi)) ok = 1'b0;
    secs = '0;
    lat  = 3;
    if (ok) begin
      days = 0;
      for (int yy = 1970; yy < yi; yy++) days += leap_y(yy) ? 366 : 365;
      for (int mm = 1; mm < moi; mm++) days += mdays(yi, mm);
      days += di - 1;
      secs = 64'(days * 86400 + hi * 3600 + mii * 60 + si);
      lat  = 4 + (yi - 1970) + (moi - 1);
`ifdef BCD_TO_UNIX_TZ_EN
      if (secs < 64'(TZH * 3600)) ok = 1'b0;
      else secs = secs - 64'(TZH * 3600);
`endif
    end
  endfunction

  task automatic issue(input logic [15:0] y, input logic [7:0] mo, d, h, mi, s);
    int          budget;
    exp_t        e;
    logic        ok;
    logic [63:0] secs;
    int          lat;
    budget = 0;
    @(negedge clk);
    while (busy && budget < 400) begin
      @(negedge clk);
      budget++;
    end
    check("issue_wait_busy", busy, 0);
    year_bcd = y; month_bcd = mo; day_bcd = d; hour_bcd = h; min_bcd = mi; sec_bcd = s;
    start = 1'b1;
    model(y, mo, d, h, mi, s, ok, secs, lat);
    if (ok) last_counter = secs;
    last_err = !ok;
    e.err  = !ok;
    e.secs = last_counter;
    e.due  = cyc + 1 + lat;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    year_bcd = 16'($urandom); month_bcd = 8'($urandom); day_bcd = 8'($urandom);
    hour_bcd = 8'($urandom);  min_bcd = 8'($urandom);   sec_bcd = 8'($urandom);
  endtask

  task automatic wait_idle();
    int budget;
    budget = 0;
    while ((sb.size() != 0 || busy) && budget < 400) begin
      @(negedge clk);
      budget++;
    end
    check("drain", 64'(sb.size()), 0);
    sb.delete();
    check("error_hold", error, last_err);
    check("counter_hold", counter, last_counter);
  endtask

  always @(negedge clk) begin
    if (reset_n && done) begin
      if (sb.size() == 0) begin
        check("spurious_done", done, 0);
      end else begin
        mon_e = sb.pop_front();
        n_txn++;
        check("error", error, mon_e.err);
        check("counter", counter, mon_e.secs);
        check("load_n", load_n, mon_e.err);
        check("latency", 64'(cyc), 64'(mon_e.due));
        $display("txn %0d: cycle=%0d error=%0d counter=%0d load_n=%0d", n_txn, cyc, error, counter, load_n);
      end
    end else if (reset_n && !load_n) begin
      check("load_n_stray", load_n, 1);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_error", error, 0);
    check("reset_counter", counter, 0);
    check("reset_load_n", load_n, 1);
    reset_n = 1'b1;

    issue(16'h1970, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00); wait_idle();
    issue(16'h2000, 8'h02, 8'h29, 8'h12, 8'h34, 8'h56); wait_idle();
    issue(16'h2038, 8'h01, 8'h19, 8'h03, 8'h14, 8'h08); wait_idle();

    // error cases issued back-to-back: each start lands the cycle after the previous done
    issue(16'h2100, 8'h02, 8'h29, 8'h00, 8'h00, 8'h00);
    issue(16'h2023, 8'h02, 8'h29, 8'h00, 8'h00, 8'h00);
    issue(16'h2024, 8'h04, 8'h31, 8'h00, 8'h00, 8'h00);
    issue(16'h2024, 8'h1A, 8'h01, 8'h00, 8'h00, 8'h00);
    issue(16'h1969, 8'h12, 8'h31, 8'h23, 8'h59, 8'h59);
    issue(16'h2024, 8'h01, 8'h01, 8'h24, 8'h00, 8'h00);
    wait_idle();

    issue(16'h2024, 8'h02, 8'h29, 8'h23, 8'h59, 8'h59);
    issue(16'h1999, 8'h12, 8'h31, 8'h23, 8'h59, 8'h59);
    issue(16'h1970, 8'h01, 8'h01, 8'h08, 8'h00, 8'h00);
    issue(16'h1970, 8'h01, 8'h01, 8'h07, 8'h59, 8'h59);
    issue(16'h2099, 8'h12, 8'h31, 8'h00, 8'h00, 8'h01);
    wait_idle();

    for (int i = 0; i < 6; i++) begin
      issue(bcd16(1970 + int'($urandom_range(0, 60))), bcd8(int'($urandom_range(1, 12))),
            bcd8(int'($urandom_range(1, 28))), bcd8(int'($urandom_range(0, 23))),
            bcd8(int'($urandom_range(0, 59))), bcd8(int'($urandom_range(0, 59))));
    end
    wait_idle();

    // start while busy with different inputs must be ignored
    issue(16'h2000, 8'h02, 8'h29, 8'h12, 8'h34, 8'h56);
    repeat (5) @(negedge clk);
    year_bcd = 16'h2030; month_bcd = 8'h05; day_bcd = 8'h05;
    hour_bcd = 8'h05; min_bcd = 8'h05; sec_bcd = 8'h05;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle();
    repeat (40) @(negedge clk);

    // reset in the middle of the YEAR loop aborts without a done
    issue(16'h2060, 8'h06, 8'h15, 8'h10, 8'h00, 8'h00);
    repeat (20) @(negedge clk);
    reset_n = 1'b0;
    sb.delete();
    last_counter = '0;
    last_err = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_error", error, 0);
    check("abort_counter", counter, 0);
    check("abort_load_n", load_n, 1);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (150) @(negedge clk);
    check("abort_idle_busy", busy, 0);

    issue(16'h2038, 8'h01, 8'h19, 8'h03, 8'h14, 8'h08); wait_idle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
